// File: rtl/key_react_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_react_capture_if
//  Description : Bundle between the main reaction-tester state machine and
//                the key capture block. The master (main FSM) drives the
//                current state and player; the slave (key_react_capture)
//                returns the press strobe, early-press flag, live reaction
//                time, and per-player turn index and average.
//  Signals     : machine_state[2:0] cur_player      (master -> slave)
//                press_pulse early_press react_time[9:0]
//                test_turn_A/B[2:0] avr_react_time_A/B[9:0] (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface key_react_capture_if;
    logic [2:0] machine_state;
    logic       cur_player;
    logic       press_pulse;
    logic       early_press;
    logic [9:0] react_time;
    logic [2:0] test_turn_A;
    logic [2:0] test_turn_B;
    logic [9:0] avr_react_time_A;
    logic [9:0] avr_react_time_B;

    modport master (
        output machine_state, cur_player,
        input  press_pulse, early_press, react_time,
               test_turn_A, test_turn_B, avr_react_time_A, avr_react_time_B
    );

    modport slave (
        input  machine_state, cur_player,
        output press_pulse, early_press, react_time,
               test_turn_A, test_turn_B, avr_react_time_A, avr_react_time_B
    );
endinterface
`default_nettype wire

// File: rtl/key_react_capture.sv
`default_nettype none
// ============================================================================
//  Module      : key_react_capture
//  Description : Debounces the two active-low player keys, measures the
//                reaction time in ms while the main FSM is in START, and
//                accumulates eight samples per player to produce a turn
//                index and a truncated average.
//  Ports       : clk, rstn (async, active-low), key_A, key_B (raw keys),
//                bus (key_react_capture_if.slave: state/player in,
//                press strobe, early flag, react time, turn, average out)
//  Revision    : 1.0 - initial release
// ============================================================================
module key_react_capture #(
    parameter int TICK_DIV  = 50000,
    parameter int DEB_TICKS = 10,
    parameter int MAX_MS    = 999
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             key_A,
    input  wire logic             key_B,
    key_react_capture_if.slave    bus
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT     = 3'd1;
    localparam logic [2:0] ST_CLR_CNT1 = 3'd2;
    localparam logic [2:0] ST_START    = 3'd3;
    localparam logic [2:0] ST_STORAGE  = 3'd4;
    localparam logic [2:0] ST_CLR_CNT2 = 3'd5;
    localparam logic [2:0] ST_AVERAGE  = 3'd6;

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W = (DEB_TICKS > 2) ? $clog2(DEB_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);
    localparam logic [9:0]       MAX_CNT  = 10'(MAX_MS);

    // ------------------------------------------------------------------
    // 1 ms tick: free-running divider, tick on the terminal count
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-key synchronizer + debouncer. Index 1 = A, 0 = B so the key
    // can be selected directly by cur_player.
    // ------------------------------------------------------------------
    logic [1:0] key_raw;
    logic [1:0] key_fall;

    assign key_raw = {key_A, key_B};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic [1:0]       sync;
        logic             deb;
        logic             deb_d;
        logic [DEB_W-1:0] stable_cnt;

        // stable_cnt counts consecutive tick samples that disagree with
        // the accepted level; any agreeing sample restarts the count.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync       <= 2'b11;
                deb        <= 1'b1;
                deb_d      <= 1'b1;
                stable_cnt <= '0;
            end else begin
                sync  <= {sync[0], key_raw[k]};
                deb_d <= deb;
                if (tick) begin
                    if (sync[1] == deb) begin
                        stable_cnt <= '0;
                    end else if (stable_cnt == DEB_LAST) begin
                        deb        <= sync[1];
                        stable_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end
            end
        end

        assign key_fall[k] = deb_d & ~deb;
    end

    // ------------------------------------------------------------------
    // Reaction measurement
    // ------------------------------------------------------------------
    logic [2:0] prev_state;
    logic       captured;
    logic       press_pulse;
    logic       early_press;
    logic [9:0] react_time;
    logic       press_evt;
    logic       press_accept;
    logic       store_en;
    logic       avg_en;

    assign press_evt    = key_fall[bus.cur_player];
    assign press_accept = press_evt && (bus.machine_state == ST_START) && !captured;
    assign store_en     = (bus.machine_state == ST_STORAGE) && (prev_state != ST_STORAGE);
    assign avg_en       = (bus.machine_state == ST_AVERAGE) && (prev_state != ST_AVERAGE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_state  <= ST_IDLE;
            captured    <= 1'b0;
            press_pulse <= 1'b0;
            early_press <= 1'b0;
            react_time  <= '0;
        end else begin
            prev_state  <= bus.machine_state;
            press_pulse <= press_accept;

            if (bus.machine_state == ST_CLR_CNT1) begin
                captured <= 1'b0;
            end else if (press_accept) begin
                captured <= 1'b1;
            end

            if ((bus.machine_state == ST_IDLE) || (bus.machine_state == ST_CLR_CNT1)) begin
                early_press <= 1'b0;
            end else if ((bus.machine_state == ST_WAIT) && press_evt) begin
                early_press <= 1'b1;
            end

            // A press coinciding with a tick wins: the count freezes at
            // its pre-increment value.
            if ((bus.machine_state == ST_CLR_CNT1) || (bus.machine_state == ST_CLR_CNT2)) begin
                react_time <= '0;
            end else if ((bus.machine_state == ST_START) && !captured && !press_accept &&
                         tick && (react_time < MAX_CNT)) begin
                react_time <= react_time + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-player accumulation and averaging. Index 1 = A, 0 = B.
    // ------------------------------------------------------------------
    logic [2:0] turn [2];
    logic [9:0] avr  [2];

    for (genvar p = 0; p < 2; p++) begin : g_player
        logic [3:0]  n;
        logic [12:0] sum;
        logic [9:0]  avr_q;
        logic        sel;

        assign sel = (bus.cur_player == 1'(p));

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                n     <= '0;
                sum   <= '0;
                avr_q <= '0;
            end else if (bus.machine_state == ST_IDLE) begin
                n     <= '0;
                sum   <= '0;
                avr_q <= '0;
            end else begin
                if (store_en && sel && (n < 4'd8)) begin
                    sum <= sum + 13'(react_time);
                    n   <= n + 4'd1;
                end
                if (avg_en && sel && (n == 4'd8)) begin
                    avr_q <= sum[12:3];
                end
            end
        end

        // n in 1..8 maps to 0..7; n = 8 wraps its low bits to 0, so
        // subtracting one yields 7 without a wider intermediate.
        assign turn[p] = (n == 4'd0) ? 3'd0 : (n[2:0] - 3'd1);
        assign avr[p]  = avr_q;
    end

    assign bus.press_pulse      = press_pulse;
    assign bus.early_press      = early_press;
    assign bus.react_time       = react_time;
    assign bus.test_turn_A      = turn[1];
    assign bus.test_turn_B      = turn[0];
    assign bus.avr_react_time_A = avr[1];
    assign bus.avr_react_time_B = avr[0];

endmodule
`default_nettype wire

// File: tb/tb_key_react_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_react_capture
//  Description : Self-checking bench for key_react_capture with a fast tick
//                (TICK_DIV=10, DEB_TICKS=3). Expected values come from the
//                ms/tick arithmetic and a per-player queue of stored samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_react_capture;

    localparam int T = 10;
    localparam int D = 3;
    localparam int MAXV = 999;

    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_CLR1 = 3'd2, S_START = 3'd3,
                           S_STORE = 3'd4, S_CLR2 = 3'd5, S_AVG = 3'd6;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic key_A = 1'b1;
    logic key_B = 1'b1;

    key_react_capture_if bus ();

    key_react_capture #(.TICK_DIV(T), .DEB_TICKS(D), .MAX_MS(MAXV)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .key_A (key_A),
        .key_B (key_B),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int qA[$];
    int qB[$];

    always @(negedge clk) if (bus.press_pulse === 1'b1) pulses++;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_start();
        bus.machine_state = S_CLR1;
        cyc(1);
        bus.machine_state = S_START;
    endtask

    task automatic test_reset();
        bus.machine_state = S_IDLE;
        bus.cur_player    = 1'b1;
        rstn = 1'b0;
        cyc(3);
        rstn = 1'b1;
        cyc(50 * T);
        tests++; if (bus.react_time !== 10'd0 || bus.early_press !== 1'b0) begin
            fails++; $display("FAIL reset_meas: react=%0d early=%0b expected 0/0", bus.react_time, bus.early_press);
        end
        tests++; if (bus.test_turn_A !== 3'd0 || bus.test_turn_B !== 3'd0) begin
            fails++; $display("FAIL reset_turn: A=%0d B=%0d expected 0", bus.test_turn_A, bus.test_turn_B);
        end
        tests++; if (bus.avr_react_time_A !== 10'd0 || bus.avr_react_time_B !== 10'd0) begin
            fails++; $display("FAIL reset_avr: A=%0d B=%0d expected 0", bus.avr_react_time_A, bus.avr_react_time_B);
        end
        tests++; if (pulses !== 0) begin
            fails++; $display("FAIL reset_pulse: pulses=%0d expected 0", pulses);
        end
    endtask

    // Press after n whole ms in START: n ticks before the key, up to one
    // more while it crosses the synchronizer, then D debounce ticks.
    task automatic test_press(input int n);
        int p0, i, v;
        bus.cur_player = 1'b1;
        clr_start();
        tests++; if (bus.react_time !== 10'd0) begin
            fails++; $display("FAIL press_clear: react=%0d expected 0", bus.react_time);
        end
        p0 = pulses;
        cyc(n * T);
        key_A = 1'b0;
        for (i = 0; i < 6 * T && pulses == p0; i++) cyc(1);
        tests++; if (pulses != p0 + 1) begin
            fails++; $display("FAIL press_pulse_timeout: pulses=%0d expected %0d", pulses - p0, 1);
        end
        v = bus.react_time;
        tests++; if (v < n + D || v > n + D + 1) begin
            fails++; $display("FAIL press_react: react=%0d expected %0d..%0d", v, n + D, n + D + 1);
        end
        cyc(5 * T);
        tests++; if (bus.react_time !== 10'(v) || pulses != p0 + 1) begin
            fails++; $display("FAIL press_freeze: react=%0d pulses=%0d expected %0d/1", bus.react_time, pulses - p0, v);
        end
        key_A = 1'b1;
        cyc((D + 3) * T);
        bus.machine_state = S_WAIT;
        cyc(2);
    endtask

    task automatic test_bounce();
        int p0;
        bus.cur_player = 1'b1;
        clr_start();
        cyc(50 * T);
        p0 = pulses;
        for (int k = 0; k < 5; k++) begin
            key_A = 1'b0;
            cyc($urandom_range(3, 2 * T));
            key_A = 1'b1;
            cyc($urandom_range(3, 2 * T));
        end
        key_A = 1'b0;
        cyc((D + 4) * T);
        tests++; if (pulses != p0 + 1) begin
            fails++; $display("FAIL bounce_pulses: pulses=%0d expected 1", pulses - p0);
        end
        // Short release glitches while held must not re-arm a press.
        for (int k = 0; k < 3; k++) begin
            key_A = 1'b1; cyc($urandom_range(3, 2 * T));
            key_A = 1'b0; cyc($urandom_range(3, 2 * T));
        end
        cyc((D + 2) * T);
        tests++; if (pulses != p0 + 1) begin
            fails++; $display("FAIL bounce_held: pulses=%0d expected 1", pulses - p0);
        end
        key_A = 1'b1;
        cyc((D + 3) * T);
        bus.machine_state = S_WAIT;
        cyc(2);
    endtask

    task automatic test_other_key();
        int p0;
        bus.cur_player = 1'b1;
        p0 = pulses;
        clr_start();
        cyc(20 * T);
        key_B = 1'b0;
        cyc(10 * T);
        tests++; if (bus.react_time !== 10'd30 || pulses != p0) begin
            fails++; $display("FAIL other_key: react=%0d pulses=%0d expected 30/0", bus.react_time, pulses - p0);
        end
        key_B = 1'b1;
        cyc((D + 3) * T);
        bus.machine_state = S_WAIT;
        cyc(2);
    endtask

    task automatic test_early();
        int p0;
        bus.cur_player = 1'b1;
        bus.machine_state = S_WAIT;
        p0 = pulses;
        key_A = 1'b0;
        cyc((D + 4) * T);
        key_A = 1'b1;
        cyc((D + 3) * T);
        tests++; if (bus.early_press !== 1'b1 || pulses != p0) begin
            fails++; $display("FAIL early_set: early=%0b pulses=%0d expected 1/0", bus.early_press, pulses - p0);
        end
        bus.machine_state = S_CLR1;
        cyc(1);
        tests++; if (bus.early_press !== 1'b0) begin
            fails++; $display("FAIL early_clear: early=%0b expected 0", bus.early_press);
        end
        bus.machine_state = S_WAIT;
        cyc(2);
    endtask

    task automatic test_saturate();
        clr_start();
        cyc(998 * T);
        tests++; if (bus.react_time !== 10'd998) begin
            fails++; $display("FAIL sat_pre: react=%0d expected 998", bus.react_time);
        end
        cyc(102 * T);
        tests++; if (bus.react_time !== 10'(MAXV)) begin
            fails++; $display("FAIL sat_max: react=%0d expected %0d", bus.react_time, MAXV);
        end
        bus.machine_state = S_CLR2;
        cyc(1);
        tests++; if (bus.react_time !== 10'd0) begin
            fails++; $display("FAIL clr_cnt2: react=%0d expected 0", bus.react_time);
        end
        bus.machine_state = S_WAIT;
        cyc(1);
    endtask

    // One measurement of exactly v ms, then STORAGE for a few cycles.
    task automatic measure(input logic pl, input int v);
        int turn_exp;
        bus.cur_player = pl;
        clr_start();
        cyc(v * T);
        tests++; if (bus.react_time !== 10'(v)) begin
            fails++; $display("FAIL meas_react: react=%0d expected %0d", bus.react_time, v);
        end
        bus.machine_state = S_STORE;
        cyc($urandom_range(1, 3));
        if (pl) begin
            if (qA.size() < 8) qA.push_back(v);
            turn_exp = (qA.size() == 0) ? 0 : qA.size() - 1;
            tests++; if (bus.test_turn_A !== 3'(turn_exp)) begin
                fails++; $display("FAIL turn_A: got %0d expected %0d", bus.test_turn_A, turn_exp);
            end
        end else begin
            if (qB.size() < 8) qB.push_back(v);
            turn_exp = (qB.size() == 0) ? 0 : qB.size() - 1;
            tests++; if (bus.test_turn_B !== 3'(turn_exp)) begin
                fails++; $display("FAIL turn_B: got %0d expected %0d", bus.test_turn_B, turn_exp);
            end
        end
        bus.machine_state = S_WAIT;
        cyc(1);
    endtask

    function automatic int avg_of(input int q[$]);
        int s = 0;
        if (q.size() < 8) return -1;
        foreach (q[i]) s += q[i];
        return s / 8;
    endfunction

    task automatic do_average(input logic pl);
        bus.cur_player = pl;
        bus.machine_state = S_AVG;
        cyc($urandom_range(1, 3));
        bus.machine_state = S_WAIT;
        cyc(1);
    endtask

    task automatic test_average();
        int ea, eb;
        bus.machine_state = S_IDLE;
        cyc(2);
        qA.delete(); qB.delete();
        for (int k = 1; k <= 8; k++) measure(1'b1, 100 * k);
        do_average(1'b1);
        ea = avg_of(qA);
        tests++; if (bus.avr_react_time_A !== 10'(ea) || bus.test_turn_A !== 3'd7) begin
            fails++; $display("FAIL avg_A: avr=%0d turn=%0d expected %0d/7", bus.avr_react_time_A, bus.test_turn_A, ea);
        end
        measure(1'b1, 555);
        do_average(1'b1);
        tests++; if (bus.avr_react_time_A !== 10'(ea) || bus.test_turn_A !== 3'd7) begin
            fails++; $display("FAIL avg_A_9th: avr=%0d turn=%0d expected %0d/7", bus.avr_react_time_A, bus.test_turn_A, ea);
        end
        for (int k = 0; k < 3; k++) measure(1'b0, $urandom_range(0, 120));
        do_average(1'b0);
        tests++; if (bus.avr_react_time_B !== 10'd0) begin
            fails++; $display("FAIL avg_B_partial: avr=%0d expected 0", bus.avr_react_time_B);
        end
        for (int k = 0; k < 5; k++) measure(1'b0, $urandom_range(0, 120));
        do_average(1'b0);
        eb = avg_of(qB);
        tests++; if (bus.avr_react_time_B !== 10'(eb) || bus.avr_react_time_A !== 10'(ea)) begin
            fails++; $display("FAIL avg_B: B=%0d A=%0d expected %0d/%0d", bus.avr_react_time_B, bus.avr_react_time_A, eb, ea);
        end
        bus.machine_state = S_IDLE;
        cyc(1);
        qA.delete(); qB.delete();
        tests++; if (bus.avr_react_time_A !== 10'd0 || bus.avr_react_time_B !== 10'd0 ||
                     bus.test_turn_A !== 3'd0 || bus.test_turn_B !== 3'd0) begin
            fails++; $display("FAIL idle_clear: avrA=%0d avrB=%0d tA=%0d tB=%0d expected 0",
                              bus.avr_react_time_A, bus.avr_react_time_B, bus.test_turn_A, bus.test_turn_B);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        bus.cur_player = 1'b1;
        clr_start();
        cyc(40 * T);
        bus.machine_state = S_WAIT;
        key_A = 1'b0;
        cyc((D + 4) * T);
        tests++; if (bus.early_press !== 1'b1 || bus.react_time !== 10'd40) begin
            fails++; $display("FAIL mid_pre: early=%0b react=%0d expected 1/40", bus.early_press, bus.react_time);
        end
        rstn = 1'b0;
        #1;
        tests++; if (bus.early_press !== 1'b0 || bus.react_time !== 10'd0) begin
            fails++; $display("FAIL mid_async: early=%0b react=%0d expected 0/0", bus.early_press, bus.react_time);
        end
        cyc(2);
        key_A = 1'b1;
        bus.machine_state = S_CLR1;
        cyc(2);
        rstn = 1'b1;
        bus.machine_state = S_START;
        p0 = pulses;
        cyc(10 * T);
        tests++; if (pulses != p0 || bus.react_time !== 10'd10) begin
            fails++; $display("FAIL mid_after: pulses=%0d react=%0d expected 0/10", pulses - p0, bus.react_time);
        end
    endtask

    initial begin
        bus.machine_state = S_IDLE;
        bus.cur_player    = 1'b1;
        test_reset();
        test_press($urandom_range(20, 200));
        test_press(120);
        test_bounce();
        test_other_key();
        test_early();
        test_saturate();
        test_average();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
